// File: rtl/idu_q.sv
// idu_q: RV32I/RV64I decode stage feeding a DEPTH-entry decoded-instruction queue
// Ports: clk, rst (async, active high), i_flush;
//   upstream   i_valid/o_ready, i_insn, i_pc;
//   downstream o_valid/i_ready, o_insn, o_pc, o_rd/o_rs1/o_rs2, o_rf_we, o_rs1_re/o_rs2_re,
//   o_imm, o_fu_cls, o_alu_op, o_word, o_lsu_size, o_lsu_sigext, o_br_f3, o_illegal, o_count.
// Optional: IDU_Q_BYPASS_EN lets an empty queue forward the decoded bundle in the same cycle.
module idu_q #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_insn,
  input  logic [XLEN-1:0]  i_pc,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [31:0]      o_insn,
  output logic [XLEN-1:0]  o_pc,
  output logic [4:0]       o_rd,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic             o_rf_we,
  output logic             o_rs1_re,
  output logic             o_rs2_re,
  output logic [XLEN-1:0]  o_imm,
  output logic [2:0]       o_fu_cls,
  output logic [3:0]       o_alu_op,
  output logic             o_word,
  output logic [1:0]       o_lsu_size,
  output logic             o_lsu_sigext,
  output logic [2:0]       o_br_f3,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_count
);
  localparam bit RV64 = XLEN == 64;
  localparam int AW = $clog2(DEPTH);
  localparam logic [2:0] BRU = 3'd1, LOAD = 3'd2, STORE = 3'd3, SYS = 3'd4;
  typedef struct packed {
    logic [31:0]     insn;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd, rs1, rs2;
    logic            rf_we, rs1_re, rs2_re;
    logic [XLEN-1:0] imm;
    logic [2:0]      fu_cls;
    logic [3:0]      alu_op;
    logic            word;
    logic [1:0]      lsu_size;
    logic            lsu_sigext;
    logic [2:0]      br_f3;
    logic            illegal;
  } bundle_t;
  function automatic logic [3:0] alu_of(input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    alu_of = alt ? 4'd1 : 4'd0;
      3'd1:    alu_of = 4'd2;
      3'd2:    alu_of = 4'd3;
      3'd3:    alu_of = 4'd4;
      3'd4:    alu_of = 4'd5;
      3'd5:    alu_of = alt ? 4'd7 : 4'd6;
      3'd6:    alu_of = 4'd8;
      default: alu_of = 4'd9;
    endcase
  endfunction
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_sh, legal, use_rd, use_rs1, use_rs2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
  bundle_t dec, head;
  assign opc = i_insn[6:0];
  assign f3 = i_insn[14:12];
  assign f7 = i_insn[31:25];
  // funct3 001/101 are the shift encodings in both OP-IMM and OP-IMM-32
  assign is_sh = f3[1:0] == 2'b01;
  assign imm_i = XLEN'($signed(i_insn[31:20]));
  assign imm_s = XLEN'($signed({i_insn[31:25], i_insn[11:7]}));
  assign imm_b = XLEN'($signed({i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({i_insn[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0}));
  assign shamt = RV64 ? XLEN'(i_insn[25:20]) : XLEN'(i_insn[24:20]);
  always_comb begin
    dec = '0;
    legal = 1'b0;
    use_rd = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    dec.insn = i_insn;
    dec.pc = i_pc;
    case (opc)
      7'b0110111: begin legal = 1'b1; use_rd = 1'b1; dec.imm = imm_u; dec.alu_op = 4'd10; end
      7'b0010111: begin legal = 1'b1; use_rd = 1'b1; dec.imm = imm_u; dec.alu_op = 4'd11; end
      7'b1101111: begin legal = 1'b1; use_rd = 1'b1; dec.imm = imm_j; dec.fu_cls = BRU; end
      7'b1100111: begin
        legal = f3 == 3'd0;
        use_rd = 1'b1;
        use_rs1 = 1'b1;
        dec.imm = imm_i;
        dec.fu_cls = BRU;
      end
      7'b1100011: begin
        legal = f3[2:1] != 2'b01;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec.imm = imm_b;
        dec.fu_cls = BRU;
        dec.br_f3 = f3;
      end
      7'b0000011: begin
        legal = f3 != 3'd7 && (RV64 || (f3 != 3'd3 && f3 != 3'd6));
        use_rd = 1'b1;
        use_rs1 = 1'b1;
        dec.imm = imm_i;
        dec.fu_cls = LOAD;
        dec.lsu_size = f3[1:0];
        dec.lsu_sigext = !f3[2];
      end
      7'b0100011: begin
        legal = !f3[2] && (RV64 || f3 != 3'd3);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec.imm = imm_s;
        dec.fu_cls = STORE;
        dec.lsu_size = f3[1:0];
      end
      7'b0010011: begin
        // slli needs funct6=0, srli/srai funct6=0/010000; shamt[5] only exists on RV64
        legal = !is_sh || (!i_insn[31] && i_insn[29:26] == 4'd0 && (f3[2] || !i_insn[30]) && (RV64 || !i_insn[25]));
        use_rd = 1'b1;
        use_rs1 = 1'b1;
        dec.imm = is_sh ? shamt : imm_i;
        dec.alu_op = alu_of(f3, is_sh && i_insn[30]);
      end
      7'b0011011: begin
        legal = RV64 && (f3 == 3'd0 || (is_sh && (f7 == 7'h00 || (f7 == 7'h20 && f3[2]))));
        use_rd = 1'b1;
        use_rs1 = 1'b1;
        dec.imm = is_sh ? shamt : imm_i;
        dec.alu_op = alu_of(f3, is_sh && f7[5]);
        dec.word = 1'b1;
      end
      7'b0110011: begin
        legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        use_rd = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec.alu_op = alu_of(f3, f7[5]);
      end
      7'b0111011: begin
        legal = RV64 && (f3 == 3'd0 || is_sh) && (f7 == 7'h00 || (f7 == 7'h20 && f3 != 3'd1));
        use_rd = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        dec.alu_op = alu_of(f3, f7[5]);
        dec.word = 1'b1;
      end
      7'b0001111: begin legal = f3 == 3'd0; dec.fu_cls = SYS; end
      7'b1110011: begin legal = i_insn == 32'h0000_0073 || i_insn == 32'h0010_0073; dec.fu_cls = SYS; end
      default: ;
    endcase
    // illegal encodings travel as inert SYS bundles so the trap is taken in order
    if (!legal) begin
      dec.fu_cls = SYS;
      dec.imm = '0;
      dec.alu_op = 4'd0;
      dec.word = 1'b0;
      dec.lsu_size = 2'd0;
      dec.lsu_sigext = 1'b0;
      dec.br_f3 = 3'd0;
      use_rd = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
    dec.illegal = !legal;
    dec.rd = use_rd ? i_insn[11:7] : 5'd0;
    dec.rs1 = use_rs1 ? i_insn[19:15] : 5'd0;
    dec.rs2 = use_rs2 ? i_insn[24:20] : 5'd0;
    dec.rf_we = use_rd && i_insn[11:7] != 5'd0;
    dec.rs1_re = use_rs1;
    dec.rs2_re = use_rs2;
  end
  bundle_t mem [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic push, pop, byp;
`ifdef IDU_Q_BYPASS_EN
  assign byp = cnt_q == '0 && i_valid && i_ready && !i_flush;
`else
  assign byp = 1'b0;
`endif
  assign o_ready = cnt_q < CNT_W'(DEPTH);
  assign o_valid = cnt_q != '0 || byp;
  assign push = i_valid && o_ready && !i_flush && !byp;
  assign pop = cnt_q != '0 && i_ready && !i_flush;
  assign wr_d = i_flush ? '0 : wr_q + AW'(push);
  assign rd_d = i_flush ? '0 : rd_q + AW'(pop);
  assign cnt_d = i_flush ? '0 : cnt_q + CNT_W'(push) - CNT_W'(pop);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= dec;
  end
  assign head = byp ? dec : mem[rd_q];
  assign o_insn = head.insn;
  assign o_pc = head.pc;
  assign o_rd = head.rd;
  assign o_rs1 = head.rs1;
  assign o_rs2 = head.rs2;
  assign o_rf_we = head.rf_we;
  assign o_rs1_re = head.rs1_re;
  assign o_rs2_re = head.rs2_re;
  assign o_imm = head.imm;
  assign o_fu_cls = head.fu_cls;
  assign o_alu_op = head.alu_op;
  assign o_word = head.word;
  assign o_lsu_size = head.lsu_size;
  assign o_lsu_sigext = head.lsu_sigext;
  assign o_br_f3 = head.br_f3;
  assign o_illegal = head.illegal;
  assign o_count = cnt_q;
endmodule

// File: tb/tb_idu_q.sv
// tb_idu_q: randomized check of idu_q decode and queue against an ISA-level model
module tb_idu_q;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef IDU_Q_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct packed {
    logic [31:0] insn;
    logic [63:0] pc, imm;
    logic [4:0] rd, rs1, rs2;
    logic we, re1, re2, word, sx, ill;
    logic [2:0] cls, bf3;
    logic [3:0] alu;
    logic [1:0] sz;
    logic full, ca, cl, cs, cb;
  } exp_t;
  localparam logic [2:0] BR_F3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  localparam logic [2:0] OI_F3 [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  localparam logic [3:0] OI_ALU [6] = '{4'd0, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9};
  localparam logic [2:0] SH_F3 [3] = '{3'd1, 3'd5, 3'd5};
  localparam logic [5:0] SH_HI [3] = '{6'h00, 6'h00, 6'h10};
  localparam logic [3:0] SH_ALU [3] = '{4'd2, 4'd6, 4'd7};
  localparam logic [6:0] OP_F7 [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
  localparam logic [2:0] OP_F3 [10] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
  localparam logic [3:0] OP_ALU [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9};
  localparam logic [6:0] IW_F7 [4] = '{7'h00, 7'h00, 7'h00, 7'h20};
  localparam logic [2:0] IW_F3 [4] = '{3'd0, 3'd1, 3'd5, 3'd5};
  localparam logic [3:0] IW_ALU [4] = '{4'd0, 4'd2, 4'd6, 4'd7};
  localparam logic [6:0] RW_F7 [5] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h20};
  localparam logic [2:0] RW_F3 [5] = '{3'd0, 3'd0, 3'd1, 3'd5, 3'd5};
  localparam logic [3:0] RW_ALU [5] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7};
  logic clk = 1'b0, rst = 1'b1, i_flush = 1'b0, i_valid = 1'b0, i_ready = 1'b0;
  logic [31:0] i_insn = '0;
  logic [63:0] i_pc = '0;
  logic o_ready, o_valid, o_rf_we, o_rs1_re, o_rs2_re, o_word, o_lsu_sigext, o_illegal;
  logic [31:0] o_insn;
  logic [63:0] o_pc, o_imm;
  logic [4:0] o_rd, o_rs1, o_rs2;
  logic [2:0] o_fu_cls, o_br_f3;
  logic [3:0] o_alu_op;
  logic [1:0] o_lsu_size;
  logic [CW-1:0] o_count;
  logic v32 = 1'b0;
  logic [31:0] insn32 = '0;
  logic [31:0] pc32 = '0;
  logic rdy32, val32, we32, re1_32, re2_32, word32, sx32, ill32;
  logic [31:0] oinsn32, opc32, imm32;
  logic [4:0] rd32, rs1_32, rs2_32;
  logic [2:0] cls32, bf3_32;
  logic [3:0] alu32;
  logic [1:0] sz32;
  logic [CW-1:0] cnt32;
  int vec = 0, err = 0;
  exp_t q[$];
  exp_t nil, e;
  always #5 clk = ~clk;
  idu_q #(.XLEN(64), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_insn(i_insn), .i_pc(i_pc), .o_valid(o_valid), .i_ready(i_ready), .o_insn(o_insn),
    .o_pc(o_pc), .o_rd(o_rd), .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rf_we(o_rf_we),
    .o_rs1_re(o_rs1_re), .o_rs2_re(o_rs2_re), .o_imm(o_imm), .o_fu_cls(o_fu_cls),
    .o_alu_op(o_alu_op), .o_word(o_word), .o_lsu_size(o_lsu_size), .o_lsu_sigext(o_lsu_sigext),
    .o_br_f3(o_br_f3), .o_illegal(o_illegal), .o_count(o_count)
  );
  idu_q #(.XLEN(32), .DEPTH(DEPTH)) u32 (
    .clk(clk), .rst(rst), .i_flush(1'b0), .i_valid(v32), .o_ready(rdy32),
    .i_insn(insn32), .i_pc(pc32), .o_valid(val32), .i_ready(1'b1), .o_insn(oinsn32),
    .o_pc(opc32), .o_rd(rd32), .o_rs1(rs1_32), .o_rs2(rs2_32), .o_rf_we(we32),
    .o_rs1_re(re1_32), .o_rs2_re(re2_32), .o_imm(imm32), .o_fu_cls(cls32),
    .o_alu_op(alu32), .o_word(word32), .o_lsu_size(sz32), .o_lsu_sigext(sx32),
    .o_br_f3(bf3_32), .o_illegal(ill32), .o_count(cnt32)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic exp_t blank(input logic [31:0] insn, input logic [63:0] pc);
    exp_t r;
    r = '0;
    r.insn = insn;
    r.pc = pc;
    r.full = 1'b1;
    return r;
  endfunction
  task automatic gen(output exp_t x);
    int k, j, imm, off;
    logic [31:0] b, ib;
    logic [4:0] rd, r1, r2;
    logic [2:0] f3;
    logic [5:0] sh;
    k = int'($urandom_range(0, 14));
    rd = 5'($urandom);
    r1 = 5'($urandom);
    r2 = 5'($urandom);
    b = $urandom;
    imm = int'($urandom_range(0, 4095)) - 2048;
    ib = imm;
    sh = 6'($urandom_range(0, 63));
    f3 = 3'($urandom);
    x = blank(32'h0, {$urandom, $urandom & 32'hFFFF_FFFC});
    case (k)
      0, 1: begin
        x.insn = {b[31:12], rd, k == 0 ? 7'h37 : 7'h17};
        x.imm = {{32{b[31]}}, b[31:12], 12'h0};
        x.alu = k == 0 ? 4'd10 : 4'd11;
        x.ca = 1'b1;
        x.rd = rd; x.we = rd != 0;
      end
      2: begin
        off = (int'($urandom_range(0, 1048575)) - 524288) * 2;
        ib = off;
        x.insn = {ib[20], ib[10:1], ib[11], ib[19:12], rd, 7'h6F};
        x.imm = longint'(off);
        x.cls = 3'd1;
        x.rd = rd; x.we = rd != 0;
      end
      3: begin
        x.insn = {ib[11:0], r1, 3'd0, rd, 7'h67};
        x.imm = longint'(imm);
        x.cls = 3'd1;
        x.rd = rd; x.we = rd != 0; x.rs1 = r1; x.re1 = 1'b1;
      end
      4: begin
        j = int'($urandom_range(0, 5));
        off = imm * 2;
        ib = off;
        x.insn = {ib[12], ib[10:5], r2, r1, BR_F3[j], ib[4:1], ib[11], 7'h63};
        x.imm = longint'(off);
        x.cls = 3'd1;
        x.bf3 = BR_F3[j]; x.cb = 1'b1;
        x.rs1 = r1; x.re1 = 1'b1; x.rs2 = r2; x.re2 = 1'b1;
      end
      5: begin
        f3 = 3'($urandom_range(0, 6));
        x.insn = {ib[11:0], r1, f3, rd, 7'h03};
        x.imm = longint'(imm);
        x.cls = 3'd2;
        x.sz = f3[1:0]; x.sx = f3 < 3'd4; x.cl = 1'b1; x.cs = 1'b1;
        x.rd = rd; x.we = rd != 0; x.rs1 = r1; x.re1 = 1'b1;
      end
      6: begin
        f3 = 3'($urandom_range(0, 3));
        x.insn = {ib[11:5], r2, r1, f3, ib[4:0], 7'h23};
        x.imm = longint'(imm);
        x.cls = 3'd3;
        x.sz = f3[1:0]; x.cl = 1'b1;
        x.rs1 = r1; x.re1 = 1'b1; x.rs2 = r2; x.re2 = 1'b1;
      end
      7: begin
        j = int'($urandom_range(0, 5));
        x.insn = {ib[11:0], r1, OI_F3[j], rd, 7'h13};
        x.imm = longint'(imm);
        x.alu = OI_ALU[j]; x.ca = 1'b1;
        x.rd = rd; x.we = rd != 0; x.rs1 = r1; x.re1 = 1'b1;
      end
      8: begin
        j = int'($urandom_range(0, 2));
        x.insn = {SH_HI[j], sh, r1, SH_F3[j], rd, 7'h13};
        x.imm = 64'(sh);
        x.alu = SH_ALU[j]; x.ca = 1'b1;
        x.rd = rd; x.we = rd != 0; x.rs1 = r1; x.re1 = 1'b1;
      end
      9: begin
        j = int'($urandom_range(0, 9));
        x.insn = {OP_F7[j], r2, r1, OP_F3[j], rd, 7'h33};
        x.alu = OP_ALU[j]; x.ca = 1'b1;
        x.rd = rd; x.we = rd != 0; x.rs1 = r1; x.re1 = 1'b1; x.rs2 = r2; x.re2 = 1'b1;
      end
      10: begin
        j = int'($urandom_range(0, 3));
        x.insn = j == 0 ? {ib[11:0], r1, 3'd0, rd, 7'h1B} : {IW_F7[j], sh[4:0], r1, IW_F3[j], rd, 7'h1B};
        x.imm = j == 0 ? 64'(longint'(imm)) : 64'(sh[4:0]);
        x.alu = IW_ALU[j]; x.ca = 1'b1; x.word = 1'b1;
        x.rd = rd; x.we = rd != 0; x.rs1 = r1; x.re1 = 1'b1;
      end
      11: begin
        j = int'($urandom_range(0, 4));
        x.insn = {RW_F7[j], r2, r1, RW_F3[j], rd, 7'h3B};
        x.alu = RW_ALU[j]; x.ca = 1'b1; x.word = 1'b1;
        x.rd = rd; x.we = rd != 0; x.rs1 = r1; x.re1 = 1'b1; x.rs2 = r2; x.re2 = 1'b1;
      end
      12: begin x.insn = {4'h0, b[7:0], 13'h0, 7'h0F}; x.cls = 3'd4; end
      13: begin x.insn = $urandom_range(0, 1) != 0 ? 32'h0010_0073 : 32'h0000_0073; x.cls = 3'd4; end
      default: begin
        j = int'($urandom_range(0, 4));
        b[1:0] = j == 0 ? 2'($urandom_range(0, 2)) : b[1:0];
        x.insn = j == 0 ? b : j == 1 ? {b[31:7], 7'h7F} : j == 2 ? {7'h01, r2, r1, f3, rd, 7'h33} :
                 j == 3 ? {b[31:15], 2'b01, b[12:7], 7'h63} : {b[31:15], 3'b001, b[11:7], 7'h73};
        x.ill = 1'b1; x.cls = 3'd4; x.full = 1'b0;
      end
    endcase
  endtask
  task automatic check_head(input exp_t x);
    chk("insn", 64'(o_insn), 64'(x.insn));
    chk("pc", o_pc, x.pc);
    chk("illegal", 64'(o_illegal), 64'(x.ill));
    chk("fu_cls", 64'(o_fu_cls), 64'(x.cls));
    chk("rf_we", 64'(o_rf_we), 64'(x.we));
    chk("rs1_re", 64'(o_rs1_re), 64'(x.re1));
    chk("rs2_re", 64'(o_rs2_re), 64'(x.re2));
    if (x.full) begin
      chk("rd", 64'(o_rd), 64'(x.rd));
      chk("rs1", 64'(o_rs1), 64'(x.rs1));
      chk("rs2", 64'(o_rs2), 64'(x.rs2));
      chk("imm", o_imm, x.imm);
      chk("word", 64'(o_word), 64'(x.word));
    end
    if (x.ca) chk("alu_op", 64'(o_alu_op), 64'(x.alu));
    if (x.cl) chk("lsu_size", 64'(o_lsu_size), 64'(x.sz));
    if (x.cs) chk("lsu_sigext", 64'(o_lsu_sigext), 64'(x.sx));
    if (x.cb) chk("br_f3", 64'(o_br_f3), 64'(x.bf3));
  endtask
  task automatic cyc(input logic v, input logic r, input logic f, input exp_t x);
    int sz;
    bit byp;
    @(negedge clk);
    i_valid = v;
    i_ready = r;
    i_flush = f;
    i_insn = x.insn;
    i_pc = x.pc;
    #1;
    sz = q.size();
    byp = BYP && sz == 0 && v && r && !f;
    chk("valid", 64'(o_valid), 64'(sz != 0 || byp));
    chk("ready", 64'(o_ready), 64'(sz < DEPTH));
    chk("count", 64'(o_count), 64'(sz));
    if (byp) check_head(x);
    else if (sz != 0) check_head(q[0]);
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (sz != 0 && r) void'(q.pop_front());
      if (v && sz < DEPTH && !byp) q.push_back(x);
    end
  endtask
  logic [31:0] t32 [6] = '{32'h001080BB, 32'h0000007F, 32'h0000B083, 32'h02009093, 32'hFFF00093, 32'h01F09093};
  logic ill_t32 [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [31:0] imm_t32 [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'd31};
  initial begin
    nil = blank(32'h0, 64'h0);
    #2;
    chk("rst_valid", 64'(o_valid), 64'h0);
    chk("rst_count", 64'(o_count), 64'h0);
    chk("rst_valid32", 64'(val32), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    e = blank(32'h00500093, 64'h1000);
    e.rd = 5'd1; e.we = 1'b1; e.re1 = 1'b1; e.imm = 64'd5; e.ca = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, e);
    cyc(1'b0, 1'b1, 1'b0, nil);
    e = blank(32'h12345137, 64'h1004);
    e.rd = 5'd2; e.we = 1'b1; e.imm = 64'h12345000; e.alu = 4'd10; e.ca = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, e);
    e = blank(32'h00113423, 64'h1008);
    e.cls = 3'd3; e.sz = 2'd3; e.cl = 1'b1; e.imm = 64'd8;
    e.rs1 = 5'd2; e.re1 = 1'b1; e.rs2 = 5'd1; e.re2 = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, e);
    for (int i = 0; i < 3; i++) cyc(1'b0, i != 0, 1'b0, nil);
    e = blank(32'hFE000EE3, 64'h100C);
    e.cls = 3'd1; e.cb = 1'b1; e.re1 = 1'b1; e.re2 = 1'b1; e.imm = 64'hFFFF_FFFF_FFFF_FFFC;
    cyc(1'b1, 1'b1, 1'b0, e);
    cyc(1'b0, 1'b1, 1'b0, nil);
    for (int i = 0; i < DEPTH + 2; i++) begin gen(e); cyc(1'b1, 1'b0, 1'b0, e); end
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 1'b1, 1'b0, nil);
    for (int i = 0; i < 3; i++) begin gen(e); cyc(1'b1, 1'b0, 1'b0, e); end
    gen(e);
    cyc(1'b1, 1'b1, 1'b1, e);
    cyc(1'b0, 1'b0, 1'b0, nil);
    for (int i = 0; i < 2; i++) begin gen(e); cyc(1'b1, 1'b0, 1'b0, e); end
    @(negedge clk);
    i_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(o_valid), 64'h0);
    chk("arst_count", 64'(o_count), 64'h0);
    q.delete();
    #1 rst = 1'b0;
    for (int i = 0; i < 600; i++) begin
      gen(e);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0, e);
    end
    cyc(1'b0, 1'b0, 1'b1, nil);
    for (int k = 0; k <= 6; k++) begin
      int idx;
      @(negedge clk);
      v32 = k < 6;
      insn32 = k < 6 ? t32[k] : 32'h0;
      #1;
      idx = BYP ? k : k - 1;
      if (idx >= 0 && idx < 6) begin
        chk("x32_valid", 64'(val32), 64'h1);
        chk("x32_insn", 64'(oinsn32), 64'(t32[idx]));
        chk("x32_illegal", 64'(ill32), 64'(ill_t32[idx]));
        chk("x32_fu_cls", 64'(cls32), ill_t32[idx] ? 64'd4 : 64'd0);
        chk("x32_rf_we", 64'(we32), 64'(!ill_t32[idx]));
        if (!ill_t32[idx]) chk("x32_imm", 64'(imm32), 64'(imm_t32[idx]));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
